march_addr_sweeper: RTL

- Parametrised successor to the BIST address counter.
- Generates one bounded address sweep per start command, for the March-test controller.
- Sweep runs over a programmable [lo_addr, hi_addr] window, either up or down.
- Supports linear (column-fast) or row-fast address ordering, with explicit valid/last/done handshake flags.
- Sits between the March-element sequencer and the memory-under-test address mux.

---
 rtl/march_addr_sweeper.sv | 133 +++++++++++++
 1 files changed

// File: rtl/march_addr_sweeper.sv
// march_addr_sweeper: bounded address sweep generator for the March-test
// controller. One sweep per accepted start over [lo_addr, hi_addr], up or
// down, with linear or row-fast address mapping and valid/last/done flags.
// Optional build macro MARCH_ADDR_AUTO_REVERSE_EN: after the first pass the
// sweep reverses direction from the end bound and a pass output is added;
// done only fires after the reverse pass.
module march_addr_sweeper #(
  parameter int A_WIDTH  = 4,
  parameter int COL_BITS = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir,
  input  logic               row_fast,
  input  logic [A_WIDTH-1:0] lo_addr,
  input  logic [A_WIDTH-1:0] hi_addr,
  input  logic               en,
  output logic [A_WIDTH-1:0] address,
  output logic               valid,
  output logic               last,
  output logic               busy,
  output logic               done,
  output logic               err
`ifdef MARCH_ADDR_AUTO_REVERSE_EN
  ,
  output logic               pass
`endif
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state;
  logic [A_WIDTH-1:0] cnt;
  logic [A_WIDTH-1:0] lo_q;
  logic [A_WIDTH-1:0] hi_q;
  logic               dir_q;
  logic               rf_q;
  logic               at_end;
`ifdef MARCH_ADDR_AUTO_REVERSE_EN
  logic               pass_q;
`endif

  // Row-fast swaps the column field to the top so it drives the high address bits.
  function automatic logic [A_WIDTH-1:0] map_addr(input logic [A_WIDTH-1:0] c,
                                                  input logic rf);
    if (rf) map_addr = {c[COL_BITS-1:0], c[A_WIDTH-1:COL_BITS]};
    else    map_addr = c;
  endfunction

  // End-of-pass detect and output mapping; the counter only moves while valid,
  // so the mapped address naturally holds its last value once the sweep ends.
  always_comb begin
    at_end  = (cnt == (dir_q ? hi_q : lo_q));
    last    = valid && at_end;
    address = map_addr(cnt, rf_q);
  end

`ifdef MARCH_ADDR_AUTO_REVERSE_EN
  assign pass = pass_q;
`endif

  // Sweep control FSM: start acceptance, counter stepping and completion flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      lo_q  <= '0;
      hi_q  <= '0;
      dir_q <= 1'b0;
      rf_q  <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef MARCH_ADDR_AUTO_REVERSE_EN
      pass_q <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (lo_addr <= hi_addr) begin
              state <= RUN;
              lo_q  <= lo_addr;
              hi_q  <= hi_addr;
              dir_q <= dir;
              rf_q  <= row_fast;
              cnt   <= dir ? lo_addr : hi_addr;
              err   <= 1'b0;
              valid <= 1'b1;
              busy  <= 1'b1;
`ifdef MARCH_ADDR_AUTO_REVERSE_EN
              pass_q <= 1'b0;
`endif
            end else begin
              err <= 1'b1;
            end
          end
        end
        RUN: begin
          if (en) begin
            if (at_end) begin
`ifdef MARCH_ADDR_AUTO_REVERSE_EN
              if (!pass_q) begin
                // Counter already sits on the end bound; just turn around.
                pass_q <= 1'b1;
                dir_q  <= ~dir_q;
              end else begin
                state  <= IDLE;
                valid  <= 1'b0;
                busy   <= 1'b0;
                done   <= 1'b1;
                pass_q <= 1'b0;
              end
`else
              state <= IDLE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
`endif
            end else begin
              cnt <= dir_q ? (cnt + A_WIDTH'(1)) : (cnt - A_WIDTH'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
